// File: rtl/dac_reg_spi_arbiter_if.sv
// Signal bundle between the DAC/register SPI arbiter, its two requesters and the
// shared spi_master. The slave modport is the arbiter's view.
interface dac_reg_spi_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  dac_req;
  logic [DATA_WIDTH-1:0] dac_data;
  logic                  dac_overrun;
  logic [7:0]            dac_drop_cnt;
  logic                  reg_req;
  logic                  reg_ready;
  logic [DATA_WIDTH-1:0] reg_data;
  logic                  reg_done;
  logic                  reg_err;
  logic                  spi_start;
  logic [DATA_WIDTH-1:0] spi_data;
  logic                  spi_new_data;
  logic [1:0]            cs_dac_reg;
  logic                  busy;
  logic                  timeout;

  modport slave (
    input  dac_req, dac_data, reg_req, reg_data, spi_new_data,
    output dac_overrun, dac_drop_cnt, reg_ready, reg_done, reg_err,
           spi_start, spi_data, cs_dac_reg, busy, timeout
  );

  modport master (
    output dac_req, dac_data, reg_req, reg_data, spi_new_data,
    input  dac_overrun, dac_drop_cnt, reg_ready, reg_done, reg_err,
           spi_start, spi_data, cs_dac_reg, busy, timeout
  );
endinterface

// File: rtl/dac_reg_spi_arbiter.sv
// Shares one SPI master between the DAC sample stream and range/key register writes.
// DAC has priority; a defer counter forces a waiting register write through after a bound.
module dac_reg_spi_arbiter #(
  parameter int DATA_WIDTH       = 8,
  parameter int CS_SETUP_CYCLES  = 1,
  parameter int CS_HOLD_CYCLES   = 1,
  parameter int REG_STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  dac_reg_spi_arbiter_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    START,
    WAIT_DONE,
    CS_HOLD
  } state_e;

  localparam logic [1:0] CS_NONE    = 2'b11;
  localparam logic [1:0] CS_DAC     = 2'b01;
  localparam logic [1:0] CS_REG     = 2'b10;
  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(REG_STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            phase_cnt_q, phase_cnt_d;
  logic [7:0]            tmo_cnt_q, tmo_cnt_d;
  logic [3:0]            defer_cnt_q, defer_cnt_d;
  logic                  dac_pend_q, dac_pend_d;
  logic [DATA_WIDTH-1:0] dac_buf_q, dac_buf_d;
  logic                  reg_pend_q, reg_pend_d;
  logic [DATA_WIDTH-1:0] reg_buf_q, reg_buf_d;
  logic                  is_reg_q, is_reg_d;
  logic [1:0]            cs_q, cs_d;
  logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;
  logic                  dac_overrun_q, dac_overrun_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  reg_done_q, reg_done_d;
  logic                  reg_err_q, reg_err_d;
  logic                  timeout_q, timeout_d;
  logic                  grant_dac, grant_reg;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    defer_cnt_d   = defer_cnt_q;
    dac_pend_d    = dac_pend_q;
    dac_buf_d     = dac_buf_q;
    reg_pend_d    = reg_pend_q;
    reg_buf_d     = reg_buf_q;
    is_reg_d      = is_reg_q;
    cs_d          = cs_q;
    spi_data_d    = spi_data_q;
    drop_cnt_d    = drop_cnt_q;
    dac_overrun_d = 1'b0;
    reg_done_d    = 1'b0;
    reg_err_d     = 1'b0;
    timeout_d     = 1'b0;
    grant_dac     = 1'b0;
    grant_reg     = 1'b0;

    case (state_q)
      IDLE: begin
        if (dac_pend_q || reg_pend_q) begin
          grant_reg   = reg_pend_q && (!dac_pend_q || defer_cnt_q == STARVE_LIM);
          grant_dac   = !grant_reg;
          is_reg_d    = grant_reg;
          spi_data_d  = grant_reg ? reg_buf_q : dac_buf_q;
          cs_d        = grant_reg ? CS_REG : CS_DAC;
          phase_cnt_d = SETUP_LAST;
          state_d     = CS_SETUP;
          if (grant_reg)       defer_cnt_d = 4'd0;
          else if (reg_pend_q) defer_cnt_d = defer_cnt_q + 4'd1;
        end
      end
      CS_SETUP: begin
        if (phase_cnt_q == 4'd0) state_d = START;
        else                     phase_cnt_d = phase_cnt_q - 4'd1;
      end
      START: begin
        tmo_cnt_d = 8'd0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Completion in the last allowed cycle still counts as success.
        if (bus.spi_new_data) begin
          reg_done_d  = is_reg_q;
          phase_cnt_d = HOLD_LAST;
          state_d     = CS_HOLD;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d   = 1'b1;
          reg_done_d  = is_reg_q;
          reg_err_d   = is_reg_q;
          phase_cnt_d = HOLD_LAST;
          state_d     = CS_HOLD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      CS_HOLD: begin
        if (phase_cnt_q == 4'd0) begin
          cs_d    = CS_NONE;
          state_d = IDLE;
        end else begin
          phase_cnt_d = phase_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A sample arriving on the edge its predecessor is granted simply refills the buffer.
    if (bus.dac_req) begin
      dac_buf_d  = bus.dac_data;
      dac_pend_d = 1'b1;
      if (dac_pend_q && !grant_dac) begin
        dac_overrun_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (grant_dac) begin
      dac_pend_d = 1'b0;
    end

    if (bus.reg_req && !reg_pend_q) begin
      reg_buf_d  = bus.reg_data;
      reg_pend_d = 1'b1;
    end else if (grant_reg) begin
      reg_pend_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_cnt_q   <= 4'd0;
      tmo_cnt_q     <= 8'd0;
      defer_cnt_q   <= 4'd0;
      dac_pend_q    <= 1'b0;
      dac_buf_q     <= '0;
      reg_pend_q    <= 1'b0;
      reg_buf_q     <= '0;
      is_reg_q      <= 1'b0;
      cs_q          <= CS_NONE;
      spi_data_q    <= '0;
      dac_overrun_q <= 1'b0;
      drop_cnt_q    <= 8'd0;
      reg_done_q    <= 1'b0;
      reg_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      defer_cnt_q   <= defer_cnt_d;
      dac_pend_q    <= dac_pend_d;
      dac_buf_q     <= dac_buf_d;
      reg_pend_q    <= reg_pend_d;
      reg_buf_q     <= reg_buf_d;
      is_reg_q      <= is_reg_d;
      cs_q          <= cs_d;
      spi_data_q    <= spi_data_d;
      dac_overrun_q <= dac_overrun_d;
      drop_cnt_q    <= drop_cnt_d;
      reg_done_q    <= reg_done_d;
      reg_err_q     <= reg_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.spi_start    = (state_q == START);
  assign bus.busy         = (state_q != IDLE);
  assign bus.reg_ready    = !reg_pend_q;
  assign bus.spi_data     = spi_data_q;
  assign bus.cs_dac_reg   = cs_q;
  assign bus.dac_overrun  = dac_overrun_q;
  assign bus.dac_drop_cnt = drop_cnt_q;
  assign bus.reg_done     = reg_done_q;
  assign bus.reg_err      = reg_err_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_dac_reg_spi_arbiter.sv
// Bench for dac_reg_spi_arbiter: a transfer-timeline model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_dac_reg_spi_arbiter;

  localparam int S = 1;
  localparam int H = 1;
  localparam int L = 4;
  localparam int T = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_reg_spi_arbiter_if #(.DATA_WIDTH(8)) bus ();

  dac_reg_spi_arbiter #(
    .DATA_WIDTH(8), .CS_SETUP_CYCLES(S), .CS_HOLD_CYCLES(H),
    .REG_STARVE_LIMIT(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- fake spi_master responder ----------------
  int resp_cnt = 0;
  int resp_lat = 3;
  bit resp_en  = 1'b1;
  bit stray_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    bus.dac_req      = 1'b0;
    bus.reg_req      = 1'b0;
    bus.spi_new_data = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) bus.spi_new_data = 1'b1;
    end
    if (bus.spi_start && resp_en) resp_cnt = resp_lat;
    if (stray_en && !bus.spi_new_data && $urandom_range(0, 39) == 0) bus.spi_new_data = 1'b1;
  endtask

  task automatic do_reset();
    tick();
    rst      = 1'b1;
    resp_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- behavioural model: buffers plus one transfer timeline ----------------
  bit         m_valid = 1'b0;
  bit         m_dac_pend, m_reg_pend;
  logic [7:0] m_dac_buf, m_reg_buf, m_spi_data;
  int         m_defer, m_drop;
  bit         m_ovr;
  bit         m_xfer, m_is_reg, m_tmo;
  int         m_g, m_end;
  logic [9:0] xfer_log[$];

  always @(negedge clk) begin : compare
    bit gd, gr;
    int s;
    logic [1:0] e_cs;
    bit e_fin;
    if (m_valid) begin
      e_cs  = m_xfer ? (m_is_reg ? 2'b10 : 2'b01) : 2'b11;
      e_fin = m_xfer && m_end >= 0 && cyc == m_end + 1;
      check("cs_dac_reg",   bus.cs_dac_reg,   e_cs);
      check("busy",         bus.busy,         m_xfer);
      check("spi_start",    bus.spi_start,    m_xfer && cyc == m_g + 1 + S);
      check("spi_data",     bus.spi_data,     m_spi_data);
      check("reg_ready",    bus.reg_ready,    !m_reg_pend);
      check("dac_overrun",  bus.dac_overrun,  m_ovr);
      check("dac_drop_cnt", bus.dac_drop_cnt, m_drop);
      check("reg_done",     bus.reg_done,     e_fin && m_is_reg);
      check("reg_err",      bus.reg_err,      e_fin && m_is_reg && m_tmo);
      check("timeout",      bus.timeout,      e_fin && m_tmo);
    end
    if (bus.spi_start === 1'b1) xfer_log.push_back({bus.cs_dac_reg, bus.spi_data});

    gd = 1'b0;
    gr = 1'b0;
    if (rst) begin
      m_valid    = 1'b1;
      m_dac_pend = 1'b0; m_reg_pend = 1'b0;
      m_dac_buf  = '0;   m_reg_buf  = '0;  m_spi_data = '0;
      m_defer    = 0;    m_drop     = 0;   m_ovr      = 1'b0;
      m_xfer     = 1'b0; m_is_reg   = 1'b0; m_tmo     = 1'b0;
      m_g        = 0;    m_end      = -1;
    end else if (m_valid) begin
      if (m_xfer) begin
        s = m_g + 1 + S;
        if (m_end < 0 && cyc > s) begin
          if (bus.spi_new_data)  begin m_end = cyc; m_tmo = 1'b0; end
          else if (cyc == s + T) begin m_end = cyc; m_tmo = 1'b1; end
        end
        if (m_end >= 0 && cyc == m_end + H) m_xfer = 1'b0;
      end else if (m_dac_pend || m_reg_pend) begin
        gr         = m_reg_pend && (!m_dac_pend || m_defer == L);
        gd         = !gr;
        m_xfer     = 1'b1;
        m_is_reg   = gr;
        m_g        = cyc;
        m_end      = -1;
        m_tmo      = 1'b0;
        m_spi_data = gr ? m_reg_buf : m_dac_buf;
        if (gr)              m_defer = 0;
        else if (m_reg_pend) m_defer++;
      end
      m_ovr = 1'b0;
      if (bus.dac_req) begin
        if (m_dac_pend && !gd) begin
          m_ovr = 1'b1;
          if (m_drop < 255) m_drop++;
        end
        m_dac_buf  = bus.dac_data;
        m_dac_pend = 1'b1;
      end else if (gd) begin
        m_dac_pend = 1'b0;
      end
      if (bus.reg_req && !m_reg_pend) begin
        m_reg_buf  = bus.reg_data;
        m_reg_pend = 1'b1;
      end else if (gr) begin
        m_reg_pend = 1'b0;
      end
    end
    cyc++;
  end

  function automatic logic [9:0] log_at(input int i);
    return (i < xfer_log.size()) ? xfer_log[i] : 10'h3FF;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.dac_req = 1'b0; bus.dac_data = '0;
    bus.reg_req = 1'b0; bus.reg_data = '0;
    bus.spi_new_data = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs",    bus.cs_dac_reg,   2'b11);
    check("rst_ready", bus.reg_ready,    1'b1);
    check("rst_busy",  bus.busy,         1'b0);
    check("rst_data",  bus.spi_data,     8'h00);
    check("rst_drop",  bus.dac_drop_cnt, 8'd0);

    // Single DAC word: cs low in cycle 2, start in cycle 3, cs released in cycle 12.
    tick(); bus.dac_req = 1'b1; bus.dac_data = 8'hA5; resp_lat = 7;
    @(negedge clk); check("dac_c0_cs", bus.cs_dac_reg, 2'b11);
    tick(); @(negedge clk); check("dac_c1_busy", bus.busy, 1'b0);
    tick(); @(negedge clk); check("dac_c2_cs", bus.cs_dac_reg, 2'b01);
    check("dac_c2_start", bus.spi_start, 1'b0);
    tick(); @(negedge clk); check("dac_c3_start", bus.spi_start, 1'b1);
    check("dac_c3_data", bus.spi_data, 8'hA5);
    tick(); @(negedge clk); check("dac_c4_start", bus.spi_start, 1'b0);
    repeat (7) tick();
    @(negedge clk); check("dac_c11_cs", bus.cs_dac_reg, 2'b01);
    tick(); @(negedge clk); check("dac_c12_cs", bus.cs_dac_reg, 2'b11);
    check("dac_c12_busy", bus.busy, 1'b0);

    // Single REG word.
    tick(); bus.reg_req = 1'b1; bus.reg_data = 8'h21; resp_lat = 4;
    @(negedge clk); check("reg_c0_ready", bus.reg_ready, 1'b1);
    tick(); @(negedge clk); check("reg_c1_ready", bus.reg_ready, 1'b0);
    tick(); @(negedge clk); check("reg_c2_cs", bus.cs_dac_reg, 2'b10);
    check("reg_c2_data", bus.spi_data, 8'h21);
    repeat (6) tick();
    @(negedge clk); check("reg_c8_done", bus.reg_done, 1'b1);
    check("reg_c8_err", bus.reg_err, 1'b0);
    tick(); @(negedge clk); check("reg_c9_done", bus.reg_done, 1'b0);
    check("reg_c9_ready", bus.reg_ready, 1'b1);
    check("reg_c9_cs", bus.cs_dac_reg, 2'b11);

    // Simultaneous requests: DAC first, then REG.
    repeat (3) tick();
    xfer_log.delete();
    resp_lat = 3;
    tick(); bus.dac_req = 1'b1; bus.dac_data = 8'h5C; bus.reg_req = 1'b1; bus.reg_data = 8'h3B;
    repeat (30) tick();
    check("simul_count", xfer_log.size(), 2);
    check("simul_first", log_at(0), {2'b01, 8'h5C});
    check("simul_second", log_at(1), {2'b10, 8'h3B});

    // Starvation bound: four DAC grants, one REG grant, repeating.
    do_reset();
    xfer_log.delete();
    resp_lat = 2;
    for (int i = 0; i < 70; i++) begin
      tick();
      bus.dac_req = 1'b1; bus.dac_data = 8'(i);
      bus.reg_req = 1'b1; bus.reg_data = 8'h77;
    end
    repeat (40) tick();
    for (int i = 0; i < 10; i++)
      check("starve_cs", 32'(log_at(i) >> 8), (i % 5 == 4) ? 2'b10 : 2'b01);
    check("starve_reg_data", 32'(log_at(4) & 10'h0FF), 8'h77);

    // Overrun: 0x11 then 0x22 during one transfer.
    do_reset();
    xfer_log.delete();
    resp_lat = 3;
    tick(); bus.dac_req = 1'b1; bus.dac_data = 8'h33;
    tick();
    tick();
    tick(); bus.dac_req = 1'b1; bus.dac_data = 8'h11;
    tick(); bus.dac_req = 1'b1; bus.dac_data = 8'h22;
    tick(); @(negedge clk); check("ovr_pulse", bus.dac_overrun, 1'b1);
    check("ovr_drop1", bus.dac_drop_cnt, 8'd1);
    tick(); @(negedge clk); check("ovr_pulse_end", bus.dac_overrun, 1'b0);
    repeat (30) tick();
    check("ovr_count", xfer_log.size(), 2);
    check("ovr_second_word", log_at(1), {2'b01, 8'h22});
    for (int i = 0; i < 450; i++) begin
      tick(); bus.dac_req = 1'b1; bus.dac_data = 8'($urandom);
    end
    repeat (20) tick();
    @(negedge clk); check("ovr_saturate", bus.dac_drop_cnt, 8'd255);

    // REG transfer that never completes.
    do_reset();
    resp_en = 1'b0;
    tick(); bus.reg_req = 1'b1; bus.reg_data = 8'h5A;
    repeat (258) tick();
    @(negedge clk); check("tmo_c258_timeout", bus.timeout, 1'b0);
    check("tmo_c258_cs", bus.cs_dac_reg, 2'b10);
    tick(); @(negedge clk); check("tmo_c259_timeout", bus.timeout, 1'b1);
    check("tmo_c259_done", bus.reg_done, 1'b1);
    check("tmo_c259_err", bus.reg_err, 1'b1);
    tick(); @(negedge clk); check("tmo_c260_cs", bus.cs_dac_reg, 2'b11);
    check("tmo_c260_busy", bus.busy, 1'b0);

    // Reset in the middle of WAIT_DONE with a DAC word also pending.
    tick(); bus.reg_req = 1'b1; bus.reg_data = 8'h66;
    repeat (5) tick();
    bus.dac_req = 1'b1; bus.dac_data = 8'h44;
    repeat (5) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk); check("rstmid_cs", bus.cs_dac_reg, 2'b11);
    check("rstmid_ready", bus.reg_ready, 1'b1);
    check("rstmid_done", bus.reg_done, 1'b0);
    check("rstmid_busy", bus.busy, 1'b0);
    repeat (3) tick();
    @(negedge clk); check("rstmid_idle", bus.busy, 1'b0);
    resp_en = 1'b1;

    // Randomized traffic with stray completions, dropped responses and rare resets.
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.dac_req  = ($urandom_range(0, 5) == 0);
      bus.dac_data = 8'($urandom);
      bus.reg_req  = ($urandom_range(0, 7) == 0);
      bus.reg_data = 8'($urandom);
      resp_lat     = $urandom_range(1, 10);
      resp_en      = ($urandom_range(0, 15) != 0);
      rst          = ($urandom_range(0, 799) == 0);
    end
    tick();
    rst      = 1'b0;
    stray_en = 1'b0;
    resp_en  = 1'b1;
    repeat (300) tick();
    @(negedge clk);
    check("final_idle", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
